// File: rtl/parking_occupancy_ctrl.sv
// parking_occupancy_ctrl
// Occupancy controller shared by all gates of a parking structure. Each
// gate's sensor logic sends one-cycle "car entered" (inc) and "car left"
// (dec) pulses. Every pulse is latched into a per-source pending bit. A
// round-robin scheduler applies at most one pending event per cycle to a
// single saturating occupancy counter. The counter drives the full, empty
// and entry-enable outputs, and sticky flags record anomalies.
//
// Source numbering: source 2*i is the inc of gate i, and source 2*i+1 is
// the dec of gate i.
//
// Ports:
//   clk           system clock; all state changes on the rising edge
//   reset         synchronous, active-high reset
//   inc_req       per-gate car-entered pulses
//   dec_req       per-gate car-left pulses
//   load_en       maintenance load of the occupancy counter
//   load_val      value to load (saturated to CAPACITY)
//   err_clr       clears the three sticky error flags
//   occupancy     registered car count
//   full          occupancy == CAPACITY
//   empty         occupancy == 0
//   entry_enable  ~full, opens the entry barriers
//   evt_valid     one-cycle pulse: an event was applied at the last edge
//   evt_src       source index of that event
//   overflow_err  sticky: inc serviced while full
//   underflow_err sticky: dec serviced while empty
//   lost_err      sticky: pulse arrived on an already-pending source

module parking_occupancy_ctrl #(
  parameter int N_GATES  = 2,
  parameter int CAPACITY = 50,
  parameter int CNT_W    = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_GATES-1:0]              inc_req,
  input  logic [N_GATES-1:0]              dec_req,
  input  logic                            load_en,
  input  logic [CNT_W-1:0]                load_val,
  input  logic                            err_clr,
  output logic [CNT_W-1:0]                occupancy,
  output logic                            full,
  output logic                            empty,
  output logic                            entry_enable,
  output logic                            evt_valid,
  output logic [$clog2(2*N_GATES)-1:0]    evt_src,
  output logic                            overflow_err,
  output logic                            underflow_err,
  output logic                            lost_err
);

  localparam int NSRC = 2 * N_GATES;
  localparam int SW   = $clog2(NSRC);
  localparam int SW1  = SW + 1;

  localparam logic [CNT_W-1:0] CAP    = CNT_W'(CAPACITY);
  localparam logic [SW1-1:0]   NSRC_V = SW1'(NSRC);
  localparam logic [SW-1:0]    LAST   = SW'(NSRC - 1);

  logic [NSRC-1:0]  pending;
  logic [SW-1:0]    rr_ptr;

  logic [NSRC-1:0]  req;
  logic [NSRC-1:0]  grant_vec;
  logic [NSRC-1:0]  pending_next;
  logic             grant_valid;
  logic [SW-1:0]    grant_idx;
  logic [SW1-1:0]   scan;
  logic             is_inc;
  logic             ovf_set;
  logic             unf_set;
  logic             lost_set;
  logic [CNT_W-1:0] occ_next;
  logic [SW-1:0]    rr_next;

  // Interleave the gate pulses into the flat source vector.
  always_comb begin
    req = '0;
    for (int i = 0; i < N_GATES; i++) begin
      req[2*i]   = inc_req[i];
      req[2*i+1] = dec_req[i];
    end
  end

  // Round-robin pick: the first pending source at or after rr_ptr, with
  // wrap-around. The scan index is one bit wider so that the wrap can be a
  // single conditional subtract, which also works for non-power-of-two
  // source counts. A maintenance load suppresses the grant for that cycle.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan        = '0;
    if (!load_en) begin
      for (int j = 0; j < NSRC; j++) begin
        scan = {1'b0, rr_ptr} + SW1'(j);
        if (scan >= NSRC_V) scan = scan - NSRC_V;
        if (!grant_valid && pending[scan[SW-1:0]]) begin
          grant_valid = 1'b1;
          grant_idx   = scan[SW-1:0];
        end
      end
    end
  end

  // A pulse that lands on the source granted in the same cycle refills the
  // pending bit. A pulse on a pending bit that is not being granted has
  // nowhere to go, so it is dropped and flagged.
  always_comb begin
    grant_vec = '0;
    if (grant_valid) grant_vec[grant_idx] = 1'b1;
    pending_next = (pending & ~grant_vec) | req;
    lost_set     = |(req & pending & ~grant_vec);
  end

  // Saturating counter update and error detection for the granted event.
  always_comb begin
    is_inc   = ~grant_idx[0];
    ovf_set  = grant_valid &  is_inc & (occupancy >= CAP);
    unf_set  = grant_valid & ~is_inc & (occupancy == '0);
    occ_next = occupancy;
    rr_next  = rr_ptr;
    if (load_en) begin
      occ_next = (load_val > CAP) ? CAP : load_val;
    end else if (grant_valid) begin
      if (is_inc && occupancy < CAP)       occ_next = occupancy + 1'b1;
      else if (!is_inc && occupancy != '0) occ_next = occupancy - 1'b1;
      rr_next = (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
    end
  end

  // State registers. A simultaneous err_clr is overridden by a new error.
  always_ff @(posedge clk) begin
    if (reset) begin
      occupancy     <= '0;
      pending       <= '0;
      rr_ptr        <= '0;
      evt_valid     <= 1'b0;
      evt_src       <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
      lost_err      <= 1'b0;
    end else begin
      occupancy     <= occ_next;
      pending       <= pending_next;
      rr_ptr        <= rr_next;
      evt_valid     <= grant_valid;
      if (grant_valid) evt_src <= grant_idx;
      overflow_err  <= (overflow_err  & ~err_clr) | ovf_set;
      underflow_err <= (underflow_err & ~err_clr) | unf_set;
      lost_err      <= (lost_err      & ~err_clr) | lost_set;
    end
  end

  assign full         = (occupancy == CAP);
  assign empty        = (occupancy == '0);
  assign entry_enable = ~full;

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Testbench for parking_occupancy_ctrl (N_GATES=2, CAPACITY=3).
// An event-level reference model tracks the pending events, the round-robin
// pointer, the counter and the flags using plain integers and arrays. A
// compare process checks every DUT output against this model on each falling
// edge. A directed sequence pins the model's key behaviours with literal
// values. A randomized phase follows.

module tb_parking_occupancy_ctrl;

  localparam int N_GATES  = 2;
  localparam int CAPACITY = 3;
  localparam int CNT_W    = 8;
  localparam int NSRC     = 2 * N_GATES;

  logic               clk;
  logic               reset;
  logic [N_GATES-1:0] inc_req;
  logic [N_GATES-1:0] dec_req;
  logic               load_en;
  logic [CNT_W-1:0]   load_val;
  logic               err_clr;
  logic [CNT_W-1:0]   occupancy;
  logic               full;
  logic               empty;
  logic               entry_enable;
  logic               evt_valid;
  logic [1:0]         evt_src;
  logic               overflow_err;
  logic               underflow_err;
  logic               lost_err;

  int errors = 0;
  int checks = 0;

  parking_occupancy_ctrl #(
    .N_GATES (N_GATES),
    .CAPACITY(CAPACITY),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .inc_req      (inc_req),
    .dec_req      (dec_req),
    .load_en      (load_en),
    .load_val     (load_val),
    .err_clr      (err_clr),
    .occupancy    (occupancy),
    .full         (full),
    .empty        (empty),
    .entry_enable (entry_enable),
    .evt_valid    (evt_valid),
    .evt_src      (evt_src),
    .overflow_err (overflow_err),
    .underflow_err(underflow_err),
    .lost_err     (lost_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs. Sample at the rising edge, then return all
  // pulses to zero 1 ns later.
  task automatic applyStimulus(input logic [1:0] inc, input logic [1:0] dec,
                               input logic ld, input logic [7:0] lv,
                               input logic clr, input logic rst);
    inc_req  = inc;
    dec_req  = dec;
    load_en  = ld;
    load_val = lv;
    err_clr  = clr;
    reset    = rst;
    @(posedge clk);
    #1;
    inc_req  = '0;
    dec_req  = '0;
    load_en  = 1'b0;
    load_val = '0;
    err_clr  = 1'b0;
    reset    = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(2'b00, 2'b00, 1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  // ---------------- event-level reference model ----------------
  int  m_occ;
  int  m_ptr;
  int  m_src;
  int  m_grant;
  bit  m_ev;
  bit  m_ovf, m_unf, m_lost;
  bit  m_pend [NSRC];
  bit  m_req  [NSRC];
  bit  s_ovf, s_unf, s_lost;
  bit  model_ready = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_occ = 0; m_ptr = 0; m_src = 0; m_ev = 0;
      m_ovf = 0; m_unf = 0; m_lost = 0;
      for (int k = 0; k < NSRC; k++) m_pend[k] = 0;
      model_ready = 1'b1;
    end else begin
      s_ovf = 0; s_unf = 0; s_lost = 0;
      m_grant = -1;
      for (int g = 0; g < N_GATES; g++) begin
        m_req[2*g]   = inc_req[g];
        m_req[2*g+1] = dec_req[g];
      end
      if (!load_en) begin
        for (int j = 0; j < NSRC; j++) begin
          if (m_grant < 0 && m_pend[(m_ptr + j) % NSRC]) m_grant = (m_ptr + j) % NSRC;
        end
      end
      if (load_en) begin
        m_occ = (int'(load_val) > CAPACITY) ? CAPACITY : int'(load_val);
      end else if (m_grant >= 0) begin
        if (m_grant % 2 == 0) begin
          if (m_occ < CAPACITY) m_occ++; else s_ovf = 1;
        end else begin
          if (m_occ > 0) m_occ--; else s_unf = 1;
        end
        m_ptr = (m_grant + 1) % NSRC;
        m_src = m_grant;
      end
      m_ev = (m_grant >= 0);
      for (int k = 0; k < NSRC; k++) begin
        if (k == m_grant)            m_pend[k] = m_req[k];
        else if (m_pend[k] && m_req[k]) s_lost = 1;
        else                          m_pend[k] = m_pend[k] | m_req[k];
      end
      if (err_clr) begin m_ovf = 0; m_unf = 0; m_lost = 0; end
      m_ovf  = m_ovf  | s_ovf;
      m_unf  = m_unf  | s_unf;
      m_lost = m_lost | s_lost;
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (model_ready) begin
      checkOutput("occupancy", 32'(occupancy), 32'(m_occ));
      checkOutput("full", 32'(full), 32'(m_occ == CAPACITY));
      checkOutput("empty", 32'(empty), 32'(m_occ == 0));
      checkOutput("entry_enable", 32'(entry_enable), 32'(m_occ != CAPACITY));
      checkOutput("evt_valid", 32'(evt_valid), 32'(m_ev));
      if (m_ev) checkOutput("evt_src", 32'(evt_src), 32'(m_src));
      checkOutput("overflow_err", 32'(overflow_err), 32'(m_ovf));
      checkOutput("underflow_err", 32'(underflow_err), 32'(m_unf));
      checkOutput("lost_err", 32'(lost_err), 32'(m_lost));
    end
  end

  // Directed sequence with literal expectations, then random traffic.
  initial begin
    inc_req = '0; dec_req = '0; load_en = 1'b0; load_val = '0;
    err_clr = 1'b0; reset = 1'b1;

    applyStimulus(2'b00, 2'b00, 1'b0, 8'd0, 1'b0, 1'b1);
    checkOutput("rst_occ", 32'(occupancy), 0);
    checkOutput("rst_empty", 32'(empty), 1);
    checkOutput("rst_full", 32'(full), 0);
    checkOutput("rst_entry", 32'(entry_enable), 1);
    checkOutput("rst_evt", 32'(evt_valid), 0);
    checkOutput("rst_errs", 32'({overflow_err, underflow_err, lost_err}), 0);

    // First inc: latched at the first edge, applied at the second edge.
    applyStimulus(2'b01, 2'b00, 1'b0, 8'd0, 1'b0, 1'b0);
    checkOutput("lat_occ0", 32'(occupancy), 0);
    idleCycles(1);
    checkOutput("lat_occ1", 32'(occupancy), 1);
    checkOutput("lat_evt", 32'(evt_valid), 1);
    checkOutput("lat_src", 32'(evt_src), 0);
    checkOutput("lat_empty", 32'(empty), 0);

    // dec of gate 1 empties the lot, then underflows.
    applyStimulus(2'b00, 2'b10, 1'b0, 8'd0, 1'b0, 1'b0);
    idleCycles(1);
    checkOutput("dec_occ", 32'(occupancy), 0);
    applyStimulus(2'b00, 2'b10, 1'b0, 8'd0, 1'b0, 1'b0);
    idleCycles(1);
    checkOutput("unf_occ", 32'(occupancy), 0);
    checkOutput("unf_flag", 32'(underflow_err), 1);
    checkOutput("unf_src", 32'(evt_src), 3);
    applyStimulus(2'b00, 2'b00, 1'b0, 8'd0, 1'b1, 1'b0);
    checkOutput("unf_clr", 32'(underflow_err), 0);

    // Load 200 while source 1 is pending: saturates to 3, then the dec applies.
    applyStimulus(2'b00, 2'b01, 1'b0, 8'd0, 1'b0, 1'b0);
    applyStimulus(2'b00, 2'b00, 1'b1, 8'd200, 1'b0, 1'b0);
    checkOutput("load_occ", 32'(occupancy), 3);
    checkOutput("load_full", 32'(full), 1);
    checkOutput("load_entry", 32'(entry_enable), 0);
    checkOutput("load_noevt", 32'(evt_valid), 0);
    idleCycles(1);
    checkOutput("load_dec", 32'(occupancy), 2);
    checkOutput("load_src", 32'(evt_src), 1);

    // Fill to capacity, then overflow.
    applyStimulus(2'b01, 2'b00, 1'b0, 8'd0, 1'b0, 1'b0);
    idleCycles(1);
    checkOutput("fill_full", 32'(full), 1);
    applyStimulus(2'b01, 2'b00, 1'b0, 8'd0, 1'b0, 1'b0);
    idleCycles(1);
    checkOutput("ovf_occ", 32'(occupancy), 3);
    checkOutput("ovf_evt", 32'(evt_valid), 1);
    checkOutput("ovf_flag", 32'(overflow_err), 1);
    applyStimulus(2'b00, 2'b00, 1'b0, 8'd0, 1'b1, 1'b0);
    checkOutput("ovf_clr", 32'(overflow_err), 0);

    // Sources 1 and 3 pending ahead of source 0: the second inc pulse is lost.
    applyStimulus(2'b00, 2'b11, 1'b0, 8'd0, 1'b0, 1'b0);
    applyStimulus(2'b01, 2'b00, 1'b0, 8'd0, 1'b0, 1'b0);
    applyStimulus(2'b01, 2'b00, 1'b0, 8'd0, 1'b0, 1'b0);
    checkOutput("lost_flag", 32'(lost_err), 1);
    checkOutput("lost_occ1", 32'(occupancy), 1);
    idleCycles(2);
    checkOutput("lost_occ2", 32'(occupancy), 2);
    checkOutput("lost_idle", 32'(evt_valid), 0);

    // An inc pulse in the exact grant cycle of source 0 is kept.
    applyStimulus(2'b00, 2'b00, 1'b0, 8'd0, 1'b1, 1'b0);
    applyStimulus(2'b00, 2'b00, 1'b1, 8'd0, 1'b0, 1'b0);
    applyStimulus(2'b01, 2'b00, 1'b0, 8'd0, 1'b0, 1'b0);
    applyStimulus(2'b01, 2'b00, 1'b0, 8'd0, 1'b0, 1'b0);
    checkOutput("keep_occ1", 32'(occupancy), 1);
    idleCycles(1);
    checkOutput("keep_occ2", 32'(occupancy), 2);
    checkOutput("keep_lost", 32'(lost_err), 0);

    // Reset with all four sources pending discards them.
    applyStimulus(2'b11, 2'b11, 1'b0, 8'd0, 1'b0, 1'b0);
    applyStimulus(2'b00, 2'b00, 1'b0, 8'd0, 1'b0, 1'b1);
    checkOutput("mrst_occ", 32'(occupancy), 0);
    for (int i = 0; i < 3; i++) begin
      idleCycles(1);
      checkOutput("mrst_noevt", 32'(evt_valid), 0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(2'($urandom) & 2'($urandom), 2'($urandom) & 2'($urandom),
                    1'($urandom_range(0, 39) == 0), 8'($urandom),
                    1'($urandom_range(0, 19) == 0),
                    1'($urandom_range(0, 399) == 0));
    end
    idleCycles(8);

    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
